// File: rtl/ldmx_axil_pkg.sv
// Shared AXI-Lite definitions for the LDMX register front ends:
// response codes, default error read data and the front-end FSM encoding.
package ldmx_axil_pkg;

  localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0]  AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0]  AXI_RESP_DECERR = 2'b11;
  localparam logic [31:0] AXIL_ERR_DATA   = 32'hDEADBEEF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ACC  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ACC  = 3'd3,
    ST_RD_RESP = 3'd4
  } axil_state_e;

  // Response for a finished access: no ack means the timer expired.
  function automatic logic [1:0] acc_resp(input logic ack, input logic err);
    logic [1:0] resp;
    if (!ack) begin
      resp = AXI_RESP_DECERR;
    end else if (err) begin
      resp = AXI_RESP_SLVERR;
    end else begin
      resp = AXI_RESP_OKAY;
    end
    return resp;
  endfunction

endpackage

// File: rtl/axil_timeout_cnt.sv
// 8-bit access timer: cleared when an access starts, counts waiting cycles,
// flags the terminal count so the front end can abort the access.
module axil_timeout_cnt #(
  parameter int TERM = 255
) (
  input  logic axilClk,
  input  logic axilRst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [7:0] cnt_r;

  // Wait-cycle counter; saturates at the terminal count.
  always_ff @(posedge axilClk or posedge axilRst) begin
    if (axilRst) begin
      cnt_r <= 8'd0;
    end else if (clr) begin
      cnt_r <= 8'd0;
    end else if (en && !tc) begin
      cnt_r <= cnt_r + 8'd1;
    end
  end

  assign tc = (cnt_r == 8'(TERM));

endmodule

// File: rtl/axil_reg_frontend.sv
// AXI-Lite slave that converts one access at a time into a level strobe /
// ack handshake towards the register mux, with a bounded ack timeout.
module axil_reg_frontend
  import ldmx_axil_pkg::*;
#(
  parameter int          ADDR_W   = 18,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = AXIL_ERR_DATA
) (
  input  logic              axilClk,
  input  logic              axilRst,
  input  logic [31:0]       axilReadMaster_araddr,
  input  logic              axilReadMaster_arvalid,
  input  logic              axilReadMaster_rready,
  output logic              axilReadSlave_arready,
  output logic [31:0]       axilReadSlave_rdata,
  output logic [1:0]        axilReadSlave_rresp,
  output logic              axilReadSlave_rvalid,
  input  logic [31:0]       axilWriteMaster_awaddr,
  input  logic              axilWriteMaster_awvalid,
  input  logic [31:0]       axilWriteMaster_wdata,
  input  logic [3:0]        axilWriteMaster_wstrb,
  input  logic              axilWriteMaster_wvalid,
  input  logic              axilWriteMaster_bready,
  output logic              axilWriteSlave_awready,
  output logic              axilWriteSlave_wready,
  output logic [1:0]        axilWriteSlave_bresp,
  output logic              axilWriteSlave_bvalid,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [31:0]       reg_wdata,
  output logic [3:0]        reg_wstrb,
  output logic              reg_wstr,
  output logic              reg_rstr,
  input  logic              reg_ack,
  input  logic              reg_err,
  input  logic [31:0]       reg_rdata
);

  axil_state_e       state_r, state_nxt_s;
  logic              arready_r, arready_nxt_s;
  logic              awready_r, awready_nxt_s;
  logic              wready_r, wready_nxt_s;
  logic              rvalid_r, rvalid_nxt_s;
  logic [31:0]       rdata_r, rdata_nxt_s;
  logic [1:0]        rresp_r, rresp_nxt_s;
  logic              bvalid_r, bvalid_nxt_s;
  logic [1:0]        bresp_r, bresp_nxt_s;
  logic [ADDR_W-1:0] reg_addr_r, reg_addr_nxt_s;
  logic [31:0]       reg_wdata_r, reg_wdata_nxt_s;
  logic [3:0]        reg_wstrb_r, reg_wstrb_nxt_s;
  logic              reg_wstr_r, reg_wstr_nxt_s;
  logic              reg_rstr_r, reg_rstr_nxt_s;
  logic              tmo_clr_s, tmo_en_s, tmo_tc_s;
  logic              wr_hs_s, rd_hs_s;
  logic              unused_s;

  // Byte lanes and bits above the register window carry no meaning here.
  assign unused_s = ^{axilReadMaster_araddr[31:ADDR_W+2], axilReadMaster_araddr[1:0],
                      axilWriteMaster_awaddr[31:ADDR_W+2], axilWriteMaster_awaddr[1:0]};

  // Readies are registered, so a handshake completes on the edge after they rise.
  assign wr_hs_s = awready_r && wready_r && axilWriteMaster_awvalid && axilWriteMaster_wvalid;
  assign rd_hs_s = arready_r && axilReadMaster_arvalid;

  axil_timeout_cnt #(.TERM(TIMEOUT)) u_tmo (
    .axilClk (axilClk),
    .axilRst (axilRst),
    .clr     (tmo_clr_s),
    .en      (tmo_en_s),
    .tc      (tmo_tc_s)
  );

  // Next-state and next-output decode for the access FSM.
  always_comb begin
    state_nxt_s     = state_r;
    arready_nxt_s   = 1'b0;
    awready_nxt_s   = 1'b0;
    wready_nxt_s    = 1'b0;
    rvalid_nxt_s    = rvalid_r;
    rdata_nxt_s     = rdata_r;
    rresp_nxt_s     = rresp_r;
    bvalid_nxt_s    = bvalid_r;
    bresp_nxt_s     = bresp_r;
    reg_addr_nxt_s  = reg_addr_r;
    reg_wdata_nxt_s = reg_wdata_r;
    reg_wstrb_nxt_s = reg_wstrb_r;
    reg_wstr_nxt_s  = reg_wstr_r;
    reg_rstr_nxt_s  = reg_rstr_r;
    tmo_clr_s       = 1'b0;
    tmo_en_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (wr_hs_s) begin
          state_nxt_s     = ST_WR_ACC;
          reg_wstr_nxt_s  = 1'b1;
          reg_addr_nxt_s  = axilWriteMaster_awaddr[ADDR_W+1:2];
          reg_wdata_nxt_s = axilWriteMaster_wdata;
          reg_wstrb_nxt_s = axilWriteMaster_wstrb;
          tmo_clr_s       = 1'b1;
        end else if (rd_hs_s) begin
          state_nxt_s    = ST_RD_ACC;
          reg_rstr_nxt_s = 1'b1;
          reg_addr_nxt_s = axilReadMaster_araddr[ADDR_W+1:2];
          tmo_clr_s      = 1'b1;
        end else if (awready_r || wready_r || arready_r) begin
          // Ready was offered but the master withdrew; drop it and re-arbitrate.
          state_nxt_s = ST_IDLE;
        end else if (axilWriteMaster_awvalid && axilWriteMaster_wvalid) begin
          awready_nxt_s = 1'b1;
          wready_nxt_s  = 1'b1;
        end else if (axilReadMaster_arvalid) begin
          arready_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WR_ACC: begin
        tmo_en_s = !reg_ack;
        if (reg_ack || tmo_tc_s) begin
          state_nxt_s    = ST_WR_RESP;
          reg_wstr_nxt_s = 1'b0;
          bvalid_nxt_s   = 1'b1;
          bresp_nxt_s    = acc_resp(reg_ack, reg_err);
        end else begin
          state_nxt_s = ST_WR_ACC;
        end
      end
      ST_RD_ACC: begin
        tmo_en_s = !reg_ack;
        if (reg_ack || tmo_tc_s) begin
          state_nxt_s    = ST_RD_RESP;
          reg_rstr_nxt_s = 1'b0;
          rvalid_nxt_s   = 1'b1;
          rresp_nxt_s    = acc_resp(reg_ack, reg_err);
          rdata_nxt_s    = reg_ack ? reg_rdata : ERR_DATA;
        end else begin
          state_nxt_s = ST_RD_ACC;
        end
      end
      ST_WR_RESP: begin
        if (axilWriteMaster_bready) begin
          state_nxt_s  = ST_IDLE;
          bvalid_nxt_s = 1'b0;
          bresp_nxt_s  = AXI_RESP_OKAY;
        end else begin
          state_nxt_s = ST_WR_RESP;
        end
      end
      ST_RD_RESP: begin
        if (axilReadMaster_rready) begin
          state_nxt_s  = ST_IDLE;
          rvalid_nxt_s = 1'b0;
          rdata_nxt_s  = 32'd0;
          rresp_nxt_s  = AXI_RESP_OKAY;
        end else begin
          state_nxt_s = ST_RD_RESP;
        end
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        rvalid_nxt_s   = 1'b0;
        rdata_nxt_s    = 32'd0;
        rresp_nxt_s    = AXI_RESP_OKAY;
        bvalid_nxt_s   = 1'b0;
        bresp_nxt_s    = AXI_RESP_OKAY;
        reg_wstr_nxt_s = 1'b0;
        reg_rstr_nxt_s = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any access in flight.
  always_ff @(posedge axilClk or posedge axilRst) begin
    if (axilRst) begin
      state_r     <= ST_IDLE;
      arready_r   <= 1'b0;
      awready_r   <= 1'b0;
      wready_r    <= 1'b0;
      rvalid_r    <= 1'b0;
      rdata_r     <= 32'd0;
      rresp_r     <= 2'b00;
      bvalid_r    <= 1'b0;
      bresp_r     <= 2'b00;
      reg_addr_r  <= '0;
      reg_wdata_r <= 32'd0;
      reg_wstrb_r <= 4'd0;
      reg_wstr_r  <= 1'b0;
      reg_rstr_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      arready_r   <= arready_nxt_s;
      awready_r   <= awready_nxt_s;
      wready_r    <= wready_nxt_s;
      rvalid_r    <= rvalid_nxt_s;
      rdata_r     <= rdata_nxt_s;
      rresp_r     <= rresp_nxt_s;
      bvalid_r    <= bvalid_nxt_s;
      bresp_r     <= bresp_nxt_s;
      reg_addr_r  <= reg_addr_nxt_s;
      reg_wdata_r <= reg_wdata_nxt_s;
      reg_wstrb_r <= reg_wstrb_nxt_s;
      reg_wstr_r  <= reg_wstr_nxt_s;
      reg_rstr_r  <= reg_rstr_nxt_s;
    end
  end

  assign axilReadSlave_arready  = arready_r;
  assign axilReadSlave_rdata    = rdata_r;
  assign axilReadSlave_rresp    = rresp_r;
  assign axilReadSlave_rvalid   = rvalid_r;
  assign axilWriteSlave_awready = awready_r;
  assign axilWriteSlave_wready  = wready_r;
  assign axilWriteSlave_bresp   = bresp_r;
  assign axilWriteSlave_bvalid  = bvalid_r;
  assign reg_addr               = reg_addr_r;
  assign reg_wdata              = reg_wdata_r;
  assign reg_wstrb              = reg_wstrb_r;
  assign reg_wstr               = reg_wstr_r;
  assign reg_rstr               = reg_rstr_r;

endmodule

// File: tb/tb_axil_reg_frontend.sv
// Directed plus randomized bench for axil_reg_frontend; the bench plays both
// the AXI-Lite master and the register mux and predicts every response itself.
module tb_axil_reg_frontend;

  localparam int          ADDR_W   = 18;
  localparam int          TIMEOUT  = 255;
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  logic              axilClk = 1'b0;
  logic              axilRst = 1'b1;
  logic [31:0]       araddr = 32'd0, awaddr = 32'd0, wdata = 32'd0;
  logic              arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic [3:0]        wstrb = 4'd0;
  logic              arready, rvalid, awready, wready, bvalid;
  logic [31:0]       rdata;
  logic [1:0]        rresp, bresp;
  logic [ADDR_W-1:0] reg_addr;
  logic [31:0]       reg_wdata;
  logic [3:0]        reg_wstrb;
  logic              reg_wstr, reg_rstr;
  logic              reg_ack = 1'b0, reg_err = 1'b0;
  logic [31:0]       reg_rdata = 32'd0;

  int vectors = 0;
  int miscompares = 0;
  bit both_hi = 1'b0;

  axil_reg_frontend #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
    .axilClk (axilClk), .axilRst (axilRst),
    .axilReadMaster_araddr (araddr), .axilReadMaster_arvalid (arvalid),
    .axilReadMaster_rready (rready),
    .axilReadSlave_arready (arready), .axilReadSlave_rdata (rdata),
    .axilReadSlave_rresp (rresp), .axilReadSlave_rvalid (rvalid),
    .axilWriteMaster_awaddr (awaddr), .axilWriteMaster_awvalid (awvalid),
    .axilWriteMaster_wdata (wdata), .axilWriteMaster_wstrb (wstrb),
    .axilWriteMaster_wvalid (wvalid), .axilWriteMaster_bready (bready),
    .axilWriteSlave_awready (awready), .axilWriteSlave_wready (wready),
    .axilWriteSlave_bresp (bresp), .axilWriteSlave_bvalid (bvalid),
    .reg_addr (reg_addr), .reg_wdata (reg_wdata), .reg_wstrb (reg_wstrb),
    .reg_wstr (reg_wstr), .reg_rstr (reg_rstr),
    .reg_ack (reg_ack), .reg_err (reg_err), .reg_rdata (reg_rdata)
  );

  always #5 axilClk = ~axilClk;

  always @(negedge axilClk) begin
    if (reg_wstr === 1'b1 && reg_rstr === 1'b1) both_hi = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge axilClk);
    #1;
  endtask

  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return (a >> 2) & ((32'd1 << ADDR_W) - 32'd1);
  endfunction

  task automatic wr_accept(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    while (awready !== 1'b1 && n < 10) begin tick(); n++; end
    chk("awready", awready, 1'b1);
    chk("wready", wready, 1'b1);
    chk("arready_during_wr", arready, 1'b0);
    tick();
    awvalid = 1'b0; wvalid = 1'b0; awaddr = $urandom; wdata = $urandom;
    chk("wr_strobes", {reg_wstr, reg_rstr, awready}, 3'b100);
    chk("wr_reg_addr", reg_addr, word_addr(a));
    chk("wr_reg_wdata", reg_wdata, d);
    chk("wr_reg_wstrb", reg_wstrb, s);
  endtask

  task automatic rd_accept(input logic [31:0] a);
    int n = 0;
    araddr = a; arvalid = 1'b1;
    while (arready !== 1'b1 && n < 10) begin tick(); n++; end
    chk("arready", arready, 1'b1);
    chk("rstr_before_accept", reg_rstr, 1'b0);
    tick();
    arvalid = 1'b0; araddr = $urandom;
    chk("rd_strobes", {reg_wstr, reg_rstr, arready}, 3'b010);
    chk("rd_reg_addr", reg_addr, word_addr(a));
  endtask

  // dly = strobe cycle (1-based) carrying the ack; 0 means never ack.
  task automatic run_acc(input bit is_wr, input int dly, input bit err, input logic [31:0] rdat);
    int n = 0;
    while (((is_wr ? reg_wstr : reg_rstr) === 1'b1) && n < 400) begin
      n++;
      if (n == 1) chk("rdata_idle_zero", {rvalid, rdata}, 33'd0);
      if (n == dly) begin
        reg_ack = 1'b1; reg_err = err; reg_rdata = rdat;
      end else begin
        reg_err = $urandom_range(0, 1); reg_rdata = $urandom;
      end
      tick();
      reg_ack = 1'b0; reg_err = 1'b0;
    end
    chk("strobe_cycles", n, (dly == 0) ? TIMEOUT + 1 : dly);
  endtask

  task automatic run_resp(input bit is_wr, input logic [1:0] er, input logic [31:0] ed, input int hold);
    for (int i = 0; i <= hold; i++) begin
      if (is_wr) begin
        chk("bvalid", bvalid, 1'b1);
        chk("bresp", bresp, er);
      end else begin
        chk("rvalid", rvalid, 1'b1);
        chk("rresp", rresp, er);
        chk("rdata", rdata, ed);
      end
      chk("quiet_in_resp", {reg_wstr, reg_rstr, arready, awready}, 4'd0);
      if (i < hold) begin
        reg_ack = $urandom_range(0, 1); reg_err = $urandom_range(0, 1);
        tick();
        reg_ack = 1'b0; reg_err = 1'b0;
      end
    end
    if (is_wr) bready = 1'b1; else rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    if (is_wr) chk("bvalid_done", bvalid, 1'b0);
    else chk("rvalid_rdata_done", {rvalid, rdata}, 33'd0);
  endtask

  task automatic xact(input bit is_wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int dly, input bit err,
                      input logic [31:0] rdat, input int hold);
    logic [1:0] er;
    er = (dly == 0) ? 2'b11 : (err ? 2'b10 : 2'b00);
    if (is_wr) wr_accept(a, d, s); else rd_accept(a);
    run_acc(is_wr, dly, err, rdat);
    run_resp(is_wr, er, (dly == 0) ? ERR_DATA : rdat, hold);
  endtask

  initial begin
    bit bad;
    repeat (3) tick();
    chk("reset_outputs", {arready, awready, wready, rvalid, bvalid, reg_wstr, reg_rstr,
                          rdata, rresp, bresp, reg_addr, reg_wdata, reg_wstrb}, 64'd0);
    #2 axilRst = 1'b0;
    tick();

    // Directed: basic write, basic read with held rready.
    xact(1'b1, 32'h0000_0104, 32'h1234_5678, 4'hF, 3, 1'b0, 32'd0, 2);
    chk("addr_0x41", reg_addr, 18'h41);
    xact(1'b0, 32'h0000_0008, 32'd0, 4'h0, 1, 1'b0, 32'hCAFE_0001, 5);
    // Timeout read, then ack exactly on the terminal cycle.
    xact(1'b0, 32'h0000_0010, 32'd0, 4'h0, 0, 1'b0, 32'h1111_2222, 1);
    xact(1'b0, 32'h0000_0014, 32'd0, 4'h0, TIMEOUT + 1, 1'b0, 32'h3333_4444, 0);
    // Slave error on a write.
    xact(1'b1, 32'h0003_FFFC, 32'hA5A5_5A5A, 4'h5, 2, 1'b1, 32'd0, 1);

    // Write, read and address all presented together: write wins.
    araddr = 32'h0000_0020; arvalid = 1'b1;
    wr_accept(32'h0000_0030, 32'h0BAD_F00D, 4'h3);
    chk("read_waits", {reg_rstr, arready}, 2'b00);
    run_acc(1'b1, 2, 1'b0, 32'd0);
    run_resp(1'b1, 2'b00, 32'd0, 3);
    rd_accept(32'h0000_0020);
    run_acc(1'b0, 1, 1'b0, 32'h7777_8888);
    run_resp(1'b0, 2'b00, 32'h7777_8888, 0);

    // Address without data must not start a write.
    awaddr = 32'h0000_0040; awvalid = 1'b1; wvalid = 1'b0; bad = 1'b0;
    repeat (10) begin
      tick();
      if (awready !== 1'b0 || wready !== 1'b0 || reg_wstr !== 1'b0) bad = 1'b1;
    end
    chk("aw_without_w", bad, 1'b0);
    awvalid = 1'b0;
    tick();

    // Reset in the middle of a read access.
    rd_accept(32'h0000_0050);
    tick();
    #2 axilRst = 1'b1;
    #1 chk("rstr_async_drop", {reg_rstr, rvalid}, 2'b00);
    tick();
    araddr = 32'h0000_0054; arvalid = 1'b1;
    #2 axilRst = 1'b0;
    bad = 1'b0;
    tick();
    if (rvalid !== 1'b0 || reg_rstr !== 1'b0) bad = 1'b1;
    chk("no_resp_after_rst", bad, 1'b0);
    rd_accept(32'h0000_0054);
    run_acc(1'b0, 2, 1'b0, 32'h5555_6666);
    run_resp(1'b0, 2'b00, 32'h5555_6666, 1);

    // Randomized traffic.
    for (int k = 0; k < 24; k++) begin
      xact(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
           $urandom_range(1, 6), ($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 4));
    end

    chk("strobes_exclusive", both_hi, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axil_reg_frontend.md
AXIL_REG_FRONTEND -- requirements
Module: axil_reg_frontend

Interface
REQ-001 SHALL have parameter ADDR_W, default 18, width of the word address (byte address bits [ADDR_W+1:2]).
REQ-002 SHALL have parameter TIMEOUT, default 255, cycles to wait for reg_ack before error termination; legal range 1..255.
REQ-003 SHALL have parameter ERR_DATA, default 32'hDEADBEEF, read data returned on timeout.
REQ-004 axilClk  in  1  sole clock; all logic on its rising edge.
REQ-005 axilRst  in  1  asynchronous, active-high reset.
REQ-006 axilReadMaster_araddr in 32 / _arvalid in 1 / _rready in 1: AXI-Lite read address and response-ready inputs.
REQ-007 axilReadSlave_arready out 1 / _rdata out 32 / _rresp out 2 / _rvalid out 1: AXI-Lite read outputs.
REQ-008 axilWriteMaster_awaddr in 32 / _awvalid in 1 / _wdata in 32 / _wstrb in 4 / _wvalid in 1 / _bready in 1: AXI-Lite write inputs.
REQ-009 axilWriteSlave_awready out 1 / _wready out 1 / _bresp out 2 / _bvalid out 1: AXI-Lite write outputs.
REQ-010 reg_addr  out  ADDR_W  registered word address to the register mux.
REQ-011 reg_wdata  out  32  registered write data; reg_wstrb out 4, registered byte strobes.
REQ-012 reg_wstr / reg_rstr  out  1 each  write / read strobe, level, held until reg_ack or timeout.
REQ-013 reg_ack  in  1  access-complete from the register mux; reg_err in 1, qualifies reg_ack as failed.
REQ-014 reg_rdata  in  32  read data, sampled in the cycle reg_ack=1.

Function
REQ-015 FSM states SHALL be IDLE, WR_ACC, WR_RESP, RD_ACC, RD_RESP.
REQ-016 In IDLE, a write SHALL start only when awvalid and wvalid are both 1; awready and wready SHALL then pulse 1 together for exactly one cycle.
REQ-017 In IDLE, a read SHALL start when arvalid=1 and no write is starting; arready SHALL pulse 1 for one cycle.
REQ-018 When write and read requests are both pending in IDLE, write SHALL win; the read SHALL be served after the write response completes.
REQ-019 At acceptance, address bits [ADDR_W+1:2], wdata and wstrb SHALL be captured; araddr/awaddr bits [1:0] and prot SHALL be ignored.
REQ-020 reg_wstr (WR_ACC) or reg_rstr (RD_ACC) SHALL assert in the cycle after acceptance; at most one strobe is 1 at any time.
REQ-021 An 8-bit timeout counter SHALL clear on entry to *_ACC and increment every cycle in *_ACC without reg_ack.
REQ-022 reg_ack=1 in *_ACC SHALL deassert the strobe next cycle and enter *_RESP; resp = 2'b10 (SLVERR) if reg_err=1, else 2'b00.
REQ-023 Counter reaching TIMEOUT without reg_ack SHALL enter *_RESP with resp 2'b11 (DECERR); read data SHALL be ERR_DATA.
REQ-024 reg_ack arriving in the same cycle the counter hits TIMEOUT SHALL take precedence (normal completion).
REQ-025 In RD_RESP, rvalid=1 with rdata/rresp stable until rready=1; then return to IDLE next cycle.
REQ-026 In WR_RESP, bvalid=1 with bresp stable until bready=1; then return to IDLE next cycle.
REQ-027 reg_ack outside *_ACC SHALL be ignored.
REQ-028 Minimum latency: accept cycle N, strobe at N+1, ack at N+1 gives rvalid/bvalid at N+2; one transaction outstanding maximum.
REQ-029 rdata SHALL be 0 whenever rvalid=0.

Reset
REQ-030 axilRst=1 SHALL asynchronously force state IDLE, counter 0, and all outputs (arready, awready, wready, rvalid, bvalid, reg_wstr, reg_rstr, rdata, rresp, bresp, reg_addr, reg_wdata, reg_wstrb) to 0.
REQ-031 Reset during *_ACC or *_RESP SHALL abandon the transaction without generating a response; release SHALL be treated as synchronous by the FSM (first acceptance no earlier than the second edge after deassertion).

Structure
REQ-032 AXI response codes (OKAY, SLVERR, DECERR), ERR_DATA default and FSM state encoding SHALL live in the shared package ldmx_axil_pkg.
REQ-033 One sub-module is natural: axil_timeout_cnt (clear, enable, terminal-count output); otherwise single flat module.

Verification
REQ-034 Write awaddr=0x0000_0104, wdata=0x1234_5678, ack 3 cycles after reg_wstr -> reg_addr=0x41, reg_wdata=0x12345678, reg_wstr 3 cycles high, bresp=00.
REQ-035 Read araddr=0x0000_0008, reg_rdata=0xCAFE_0001 with ack -> rdata=0xCAFE0001, rresp=00, rvalid held while rready=0 for 5 cycles.
REQ-036 Read with no reg_ack, TIMEOUT=255 -> rresp=11, rdata=0xDEADBEEF, rvalid 256 cycles after reg_rstr rises; ack at cycle 255 instead -> rresp=00.
REQ-037 awvalid, wvalid, arvalid all asserted same cycle -> write strobe first, bvalid/bready handshake, then read strobe; never both strobes high.
REQ-038 reg_ack with reg_err=1 on write -> bresp=10; awvalid without wvalid for 10 cycles -> no awready, no strobe.
REQ-039 axilRst pulsed mid RD_ACC -> rvalid never asserted, reg_rstr drops asynchronously, next read completes normally.
